// File: rtl/fsm_010_scheduler.sv
// fsm_010_scheduler
//
// Round-robin scheduler that time-shares one "010" sequence detector among
// NCH bit-serial requesters. Each channel keeps its own saved detector
// context and detection counter. One bit from one channel is consumed per
// cycle, and the shared next-state logic runs against that channel's saved
// context.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous reset, active low
//   req          per-channel valid; bit_in[i] is presented while req[i]=1
//   bit_in       per-channel serial data bit
//   clr          clear strobe for channel clr_ch (context -> S0, counter -> 0)
//   clr_ch       channel index to clear
//   gnt          one-hot grant, combinational from req, clr, rst and pointer
//   y            registered one-cycle detection pulse
//   y_ch         channel consumed in the previous cycle
//   ch_count     post-update counter of channel y_ch
//   total_count  saturating total of all detections since reset
//
// Context states
//   state | meaning
//   S0    | no useful prefix seen
//   G0    | last bit was 0
//   G01   | last two bits were 0,1; a following 0 is a detection
module fsm_010_scheduler #(
    parameter int NCH   = 4,
    parameter int CNT_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic [NCH-1:0]           bit_in,
    input  logic                     clr,
    input  logic [$clog2(NCH)-1:0]   clr_ch,
    output logic [NCH-1:0]           gnt,
    output logic                     y,
    output logic [$clog2(NCH)-1:0]   y_ch,
    output logic [CNT_W-1:0]         ch_count,
    output logic [CNT_W+1:0]         total_count
);

    localparam int CH_W = $clog2(NCH);

    typedef enum logic [1:0] {
        S0  = 2'd0,
        G0  = 2'd1,
        G01 = 2'd2
    } ctx_e;

    ctx_e               ctx_q [NCH];
    logic [CNT_W-1:0]   cnt_q [NCH];
    logic [CH_W-1:0]    ptr_q;
    logic               y_q;
    logic [CH_W-1:0]    y_ch_q;
    logic [CNT_W-1:0]   ch_count_q;
    logic [CNT_W+1:0]   total_q;

    logic [NCH-1:0]     clr_mask;
    logic [NCH-1:0]     elig;
    logic [NCH-1:0]     gnt_d;
    logic               gnt_vld;
    logic [CH_W-1:0]    gnt_idx;

    ctx_e               cur_ctx;
    logic               cur_bit;
    ctx_e               ctx_d;
    logic               det_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W+1:0]   total_d;
    logic [CH_W-1:0]    ptr_d;

    // Arbitration: the channel being cleared is never eligible, so a clear
    // always wins over consumption and its pending bit simply waits.
    always_comb begin
        int k;
        k        = 0;
        clr_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            clr_mask[i] = clr && (CH_W'(i) == clr_ch);
        end
        elig    = req & ~clr_mask & {NCH{rst}};
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int off = 0; off < NCH; off++) begin
            k = (int'(ptr_q) + off) % NCH;
            if (!gnt_vld && elig[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = CH_W'(k);
            end
        end
        gnt_d = '0;
        if (gnt_vld) begin
            gnt_d[gnt_idx] = 1'b1;
        end
    end

    assign gnt = gnt_d;

    // Shared detector evaluated against the granted channel's saved context.
    always_comb begin
        cur_ctx = ctx_q[gnt_idx];
        cur_bit = bit_in[gnt_idx];
        ctx_d   = S0;
        det_d   = 1'b0;
        case (cur_ctx)
            S0:  ctx_d = cur_bit ? S0 : G0;
            G0:  ctx_d = cur_bit ? G01 : G0;
            G01: begin
                ctx_d = cur_bit ? S0 : G0;
                det_d = !cur_bit;
            end
            default: ctx_d = S0;
        endcase

        cnt_d = cnt_q[gnt_idx];
        if (det_d && (cnt_d != '1)) begin
            cnt_d = cnt_d + 1'b1;
        end

        total_d = total_q;
        if (det_d && (total_q != '1)) begin
            total_d = total_q + 1'b1;
        end

        // Explicit wrap so non-power-of-two NCH stays within range.
        if (int'(gnt_idx) == NCH - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                ctx_q[i] <= S0;
                cnt_q[i] <= '0;
            end
            ptr_q      <= '0;
            y_q        <= 1'b0;
            y_ch_q     <= '0;
            ch_count_q <= '0;
            total_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr_mask[i]) begin
                    ctx_q[i] <= S0;
                    cnt_q[i] <= '0;
                end
            end
            // The granted channel is never the cleared one, so these writes
            // never collide with the clear above.
            if (gnt_vld) begin
                ctx_q[gnt_idx] <= ctx_d;
                cnt_q[gnt_idx] <= cnt_d;
                ptr_q          <= ptr_d;
                y_q            <= det_d;
                y_ch_q         <= gnt_idx;
                ch_count_q     <= cnt_d;
                total_q        <= total_d;
            end else begin
                y_q <= 1'b0;
            end
        end
    end

    assign y           = y_q;
    assign y_ch        = y_ch_q;
    assign ch_count    = ch_count_q;
    assign total_count = total_q;

endmodule

// File: tb/tb_fsm_010_scheduler.sv
// Testbench for fsm_010_scheduler. Two instances share the same stimulus:
// one with CNT_W=10 and one with CNT_W=2 so counter saturation is exercised.
// The reference model tracks each channel's recent bit history and raw
// (unsaturated) detection counts; expected outputs are derived from those.
module tb_fsm_010_scheduler;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic       clr;
    logic [1:0] clr_ch;

    logic [3:0]  gnt_a, gnt_b;
    logic        y_a, y_b;
    logic [1:0]  ych_a, ych_b;
    logic [9:0]  chc_a;
    logic [11:0] tot_a;
    logic [1:0]  chc_b;
    logic [3:0]  tot_b;

    fsm_010_scheduler #(.NCH(4), .CNT_W(10)) u_dut (
        .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .clr(clr),
        .clr_ch(clr_ch), .gnt(gnt_a), .y(y_a), .y_ch(ych_a),
        .ch_count(chc_a), .total_count(tot_a)
    );

    fsm_010_scheduler #(.NCH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .clr(clr),
        .clr_ch(clr_ch), .gnt(gnt_b), .y(y_b), .y_ch(ych_b),
        .ch_count(chc_b), .total_count(tot_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    int       m_ptr;
    int       m_raw [4];
    int       m_n   [4];
    logic [2:0] m_h [4];
    int       m_tot;
    logic     m_y;
    int       m_ych;
    int       m_chraw;
    int       last_g;
    logic [3:0] obs_gnt;

    function automatic int sat(input int raw, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_tot = 0; m_y = 1'b0; m_ych = 0; m_chraw = 0;
        for (int i = 0; i < 4; i++) begin
            m_raw[i] = 0; m_n[i] = 0; m_h[i] = 3'b000;
        end
    endtask

    // One clock cycle: drive at negedge, check the grant, then check the
    // registered outputs just after the rising edge.
    task automatic cyc(input logic [3:0] r, input logic [3:0] b, input logic c,
                       input logic [1:0] cc, input logic rs);
        int g;
        logic [3:0] elig;
        logic [3:0] eg;
        logic det;
        @(negedge clk);
        rst = rs; req = r; bit_in = b; clr = c; clr_ch = cc;
        #1;
        g = -1;
        elig = r & ~(c ? (4'b0001 << cc) : 4'b0000);
        if (rs) begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (g < 0 && elig[k]) g = k;
            end
        end
        eg = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        obs_gnt = gnt_a;
        check("gnt", gnt_a, eg);
        check("gnt_sat", gnt_b, eg);
        last_g = g;
        @(posedge clk);
        if (!rs) begin
            model_reset();
        end else begin
            if (c) begin
                m_raw[cc] = 0; m_n[cc] = 0; m_h[cc] = 3'b000;
            end
            if (g >= 0) begin
                m_h[g] = {m_h[g][1:0], b[g]};
                m_n[g]++;
                det = (m_n[g] >= 3) && (m_h[g] == 3'b010);
                if (det) begin
                    m_raw[g]++;
                    m_tot++;
                end
                m_y = det; m_ych = g; m_chraw = m_raw[g];
                m_ptr = (g + 1) % 4;
            end else begin
                m_y = 1'b0;
            end
        end
        #1;
        check("y", y_a, m_y);
        check("y_ch", ych_a, m_ych);
        check("ch_count", chc_a, sat(m_chraw, 10));
        check("total", tot_a, sat(m_tot, 12));
        check("y_sat", y_b, m_y);
        check("y_ch_sat", ych_b, m_ych);
        check("ch_count_sat", chc_b, sat(m_chraw, 2));
        check("total_sat", tot_b, sat(m_tot, 4));
    endtask

    task automatic do_reset();
        cyc(4'h0, 4'h0, 1'b0, 2'd0, 1'b0);
        cyc(4'h0, 4'h0, 1'b0, 2'd0, 1'b0);
    endtask

    // Per-channel bit queues; each channel requests while its queue is
    // non-empty and holds its head bit until granted.
    bit sq [4][$];

    task automatic run_streams();
        int budget;
        logic [3:0] r, b;
        budget = 0;
        while ((sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size()) > 0 && budget < 100) begin
            for (int i = 0; i < 4; i++) begin
                r[i] = (sq[i].size() > 0);
                b[i] = (sq[i].size() > 0) ? sq[i][0] : 1'b0;
            end
            cyc(r, b, 1'b0, 2'd0, 1'b1);
            if (last_g >= 0 && sq[last_g].size() > 0) void'(sq[last_g].pop_front());
            budget++;
        end
        if (budget >= 100) check("stream_budget", 32'd1, 32'd0);
    endtask

    logic [3:0] pend;

    initial begin
        rst = 1'b0; req = '0; bit_in = '0; clr = 1'b0; clr_ch = '0;
        model_reset();

        // Reset held with all channels requesting
        for (int i = 0; i < 3; i++) cyc(4'hF, 4'h0, 1'b0, 2'd0, 1'b0);
        check("rst_tot", tot_a, 32'd0);
        cyc(4'hF, 4'h0, 1'b0, 2'd0, 1'b1);
        check("first_gnt", obs_gnt, 32'h1);

        // Full contention, then channel 1 drops out
        for (int i = 0; i < 8; i++) cyc(4'hF, 4'hF, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(4'hD, 4'h0, 1'b0, 2'd0, 1'b1);

        // Single channel with overlapping detections
        do_reset();
        sq[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        run_streams();
        check("single_y", y_a, 32'd1);
        check("single_cnt", chc_a, 32'd2);
        check("single_tot", tot_a, 32'd2);

        // Context isolation between interleaved channels
        do_reset();
        sq[1] = '{1'b0, 1'b1, 1'b0};
        sq[2] = '{1'b0, 1'b1, 1'b0};
        run_streams();
        check("iso_tot", tot_a, 32'd2);

        // Saturation on the narrow instance: five detections on channel 3
        do_reset();
        sq[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        run_streams();
        check("sat_cnt", chc_b, 32'd3);
        check("sat_tot", tot_b, 32'd5);
        check("wide_cnt", chc_a, 32'd5);

        // Clear mid-sequence wins over a pending bit
        do_reset();
        sq[0] = '{1'b0, 1'b1};
        run_streams();
        cyc(4'h1, 4'h0, 1'b1, 2'd0, 1'b1);
        check("clr_gnt", obs_gnt, 32'h0);
        sq[0] = '{1'b0};
        run_streams();
        check("clr_nodet", y_a, 32'd0);
        check("clr_cnt", chc_a, 32'd0);

        // Reset mid-sequence
        do_reset();
        sq[2] = '{1'b0, 1'b1};
        run_streams();
        cyc(4'h0, 4'h0, 1'b0, 2'd0, 1'b0);
        sq[2] = '{1'b0};
        run_streams();
        check("rst_nodet", y_a, 32'd0);

        // Randomized traffic with clears and occasional resets
        do_reset();
        pend = 4'($urandom);
        for (int n = 0; n < 600; n++) begin
            logic [3:0] r;
            logic c;
            logic [1:0] cc;
            logic rs;
            r  = 4'($urandom);
            c  = ($urandom_range(0, 7) == 0);
            cc = 2'($urandom_range(0, 3));
            rs = ($urandom_range(0, 99) != 0);
            cyc(r, pend, c, cc, rs);
            if (last_g >= 0) pend[last_g] = 1'($urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
